// File: rtl/fetch_seq_pkg.sv
// Shared types for the 6502 fetch sequencer: FSM state encoding, reset
// vector default and the opcode length codes produced by op_len_dec.
package fetch_seq_pkg;

   localparam logic [15:0] RESET_VECTOR_DEF = 16'hFFFC;

   typedef enum logic [2:0] {
      ST_RST_LO    = 3'd0,
      ST_RST_HI    = 3'd1,
      ST_FETCH_OP  = 3'd2,
      ST_FETCH_LO  = 3'd3,
      ST_FETCH_HI  = 3'd4,
      ST_WAIT_EXEC = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      LEN_1 = 2'd1,
      LEN_2 = 2'd2,
      LEN_3 = 2'd3
   } op_len_e;

endpackage

// File: rtl/fetch_seq_op_len_dec.sv
// Combinational 6502 opcode length decoder: opcode byte -> 1/2/3 bytes.
// Uses the cc (op[1:0]) / bbb (op[4:2]) addressing-mode fields.
module op_len_dec
   import fetch_seq_pkg::*;
(
   input  logic [7:0] op_i,
   output op_len_e    len_o
);

   logic [1:0] cc;
   logic [2:0] bbb;
   logic       is_len3;
   logic       is_len1;

   assign cc  = op_i[1:0];
   assign bbb = op_i[4:2];

   // JSR and the absolute / absolute-indexed modes take a 16-bit operand.
   assign is_len3 = (op_i == 8'h20) || (bbb == 3'd3) || (bbb == 3'd7) ||
                    ((bbb == 3'd6) && (cc == 2'b01));

   // BRK/RTI/RTS plus the implied/accumulator columns carry no operand.
   assign is_len1 = (op_i == 8'h00) || (op_i == 8'h40) || (op_i == 8'h60) ||
                    ((bbb == 3'd2) && (cc != 2'b01)) ||
                    ((bbb == 3'd6) && (cc != 2'b01));

   always_comb begin
      len_o = LEN_2;
      if (is_len3)      len_o = LEN_3;
      else if (is_len1) len_o = LEN_1;
   end

endmodule

// File: rtl/fetch_seq.sv
// Bus-side instruction fetch sequencer: loads the reset vector, then fetches
// opcode + operand bytes and hands them to the executor until exec_done.
module fetch_seq
   import fetch_seq_pkg::*;
#(
   parameter logic [15:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic [7:0]  data_in,
   input  logic        exec_done,
   input  logic        pc_load,
   input  logic [15:0] pc_in,
   output logic [15:0] addr,
   output logic        rd,
   output logic        sync,
   output logic [7:0]  opcode,
   output logic [15:0] operand,
   output logic        instr_valid,
   output logic [15:0] pc
);

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [7:0]  opcode_q, opcode_d;
   logic [15:0] operand_q, operand_d;
   logic        instr_valid_q, instr_valid_d;
   op_len_e     len_bus, len_op;
   logic [15:0] pc_inc;

   // One decoder looks at the byte on the bus (opcode cycle), the other at
   // the latched opcode (deciding whether a high operand byte follows).
   op_len_dec u_len_bus (.op_i(data_in),  .len_o(len_bus));
   op_len_dec u_len_op  (.op_i(opcode_q), .len_o(len_op));

   assign pc_inc = pc_q + 16'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_RST_LO;
         pc_q          <= 16'h0000;
         opcode_q      <= 8'h00;
         operand_q     <= 16'h0000;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         opcode_q      <= opcode_d;
         operand_q     <= operand_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      opcode_d  = opcode_q;
      operand_d = operand_q;
      addr      = pc_q;
      rd        = 1'b1;
      sync      = 1'b0;

      case (state_q)
         ST_RST_LO: begin
            addr = RESET_VECTOR;
            if (rdy) begin
               pc_d[7:0] = data_in;
               state_d   = ST_RST_HI;
            end
         end
         ST_RST_HI: begin
            addr = RESET_VECTOR + 16'd1;
            if (rdy) begin
               pc_d[15:8] = data_in;
               state_d    = ST_FETCH_OP;
            end
         end
         ST_FETCH_OP: begin
            sync = 1'b1;
            if (rdy) begin
               opcode_d  = data_in;
               operand_d = 16'h0000;
               pc_d      = pc_inc;
               state_d   = (len_bus == LEN_1) ? ST_WAIT_EXEC : ST_FETCH_LO;
            end
         end
         ST_FETCH_LO: begin
            if (rdy) begin
               operand_d[7:0] = data_in;
               pc_d           = pc_inc;
               state_d        = (len_op == LEN_3) ? ST_FETCH_HI : ST_WAIT_EXEC;
            end
         end
         ST_FETCH_HI: begin
            if (rdy) begin
               operand_d[15:8] = data_in;
               pc_d            = pc_inc;
               state_d         = ST_WAIT_EXEC;
            end
         end
         ST_WAIT_EXEC: begin
            // The bus is idle here, so rdy has no say; pc_in only lands with exec_done.
            rd = 1'b0;
            if (exec_done) begin
               if (pc_load) pc_d = pc_in;
               state_d = ST_FETCH_OP;
            end
         end
         default: begin
            state_d = ST_RST_LO;
         end
      endcase

      instr_valid_d = (state_d == ST_WAIT_EXEC);
   end

   assign opcode      = opcode_q;
   assign operand     = operand_q;
   assign instr_valid = instr_valid_q;
   assign pc          = pc_q;

endmodule
